// File: rtl/ex_mul_unit.sv
// EX-stage iterative shift-add multiplier for RV64 MUL (low XLEN bits of the product).
// Optional feature macro: MUL_EARLY_EXIT_EN (finish as soon as the remaining multiplier is zero).
module ex_mul_unit #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     EX_Inst,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            mul_stall,
    output logic            mul_done,
    output logic [XLEN-1:0] mul_result
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] a_sh_q, a_sh_d;
    logic [XLEN-1:0] b_sh_q, b_sh_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] mul_result_q, mul_result_d;
    logic            mul_done_q, mul_done_d;

    logic            is_mul_c;
    logic [XLEN-1:0] b_next_c;
    logic            last_iter_c;
    logic            unused_inst_c;

    assign is_mul_c = (EX_Inst[6:0] == 7'b0110011) &&
                      (EX_Inst[14:12] == 3'b000) &&
                      (EX_Inst[31:25] == 7'b0000001);

    // Register fields are irrelevant to the decode.
    assign unused_inst_c = ^{EX_Inst[24:15], EX_Inst[11:7]};

    assign b_next_c = b_sh_q >> 1;

`ifdef MUL_EARLY_EXIT_EN
    assign last_iter_c = (count_q == CW'(XLEN - 1)) || (b_next_c == '0);
`else
    assign last_iter_c = (count_q == CW'(XLEN - 1));
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_mul_c) begin
`ifdef MUL_EARLY_EXIT_EN
                        state_d = (op_b == '0) ? S_DONE : S_RUN;
`else
                        state_d = S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    if (last_iter_c) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output logic
    always_comb begin
        acc_d     = acc_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        count_d   = count_q;
        mul_stall = is_mul_c && (state_q != S_DONE) && !flush && !rst;
        if (!flush) begin
            case (state_q)
                S_IDLE: begin
                    if (is_mul_c) begin
                        acc_d   = '0;
                        a_sh_d  = op_a;
                        b_sh_d  = op_b;
                        count_d = '0;
                    end
                end
                S_RUN: begin
                    if (b_sh_q[0]) begin
                        acc_d = acc_q + a_sh_q;
                    end
                    a_sh_d  = a_sh_q << 1;
                    b_sh_d  = b_next_c;
                    count_d = count_q + CW'(1);
                end
                default: ;
            endcase
        end
        mul_done_d   = (state_d == S_DONE);
        mul_result_d = ((state_d == S_DONE) && (state_q != S_DONE)) ? acc_d : mul_result_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            count_q      <= '0;
            mul_result_q <= '0;
            mul_done_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            count_q      <= count_d;
            mul_result_q <= mul_result_d;
            mul_done_q   <= mul_done_d;
        end
    end

    assign mul_done   = mul_done_q;
    assign mul_result = mul_result_q;

endmodule

// File: tb/tb_ex_mul_unit.sv
// Self-checking bench for ex_mul_unit: random operands against a product/latency model.
module tb_ex_mul_unit;

    localparam int unsigned XLEN = 64;
    localparam logic [31:0] INST_MUL  = 32'h02B5_0533;
    localparam logic [31:0] INST_ADD  = 32'h00B5_0533;
    localparam logic [31:0] INST_MULH = 32'h02B5_1533;
    localparam logic [31:0] INST_MULW = 32'h02B5_053B;
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;

    logic            clk;
    logic            rst;
    logic [31:0]     ex_inst;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            mul_stall;
    logic            mul_done;
    logic [XLEN-1:0] mul_result;

    int unsigned     n_checks = 0;
    int unsigned     n_errors = 0;
    logic [XLEN-1:0] exp_result = '0;

    ex_mul_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .EX_Inst    (ex_inst),
        .op_a       (op_a),
        .op_b       (op_b),
        .flush      (flush),
        .mul_stall  (mul_stall),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycle index (counted from the cycle the MUL first sits in EX) at which mul_done is expected.
    function automatic int done_cycle(input logic [XLEN-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int msb;
        if (b == '0) return 1;
        msb = 0;
        for (int i = 0; i < int'(XLEN); i++) if (b[i]) msb = i;
        return msb + 2;
`else
        return int'(XLEN) + 1;
`endif
    endfunction

    // Apply inputs for one cycle and let combinational outputs settle.
    task automatic drive(input logic [31:0] inst, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic fl, input logic r);
        @(negedge clk);
        ex_inst = inst;
        op_a    = a;
        op_b    = b;
        flush   = fl;
        rst     = r;
        #1;
    endtask

    // A full MUL: instruction held in EX until its DONE cycle.
    task automatic run_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int lat;
        lat = done_cycle(b);
        for (int k = 0; k <= lat; k++) begin
            drive(INST_MUL, a, b, 1'b0, 1'b0);
            chk($sformatf("stall k=%0d", k), XLEN'(mul_stall), XLEN'(k < lat));
            chk($sformatf("done k=%0d", k), XLEN'(mul_done), XLEN'(k == lat));
            if (k == lat) begin
                exp_result = a * b;
                chk("result", mul_result, exp_result);
            end
        end
    endtask

    // A MUL killed by flush or reset in cycle kill_at; EX then holds a bubble.
    task automatic abort_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             input int kill_at, input logic use_rst);
        for (int k = 0; k <= kill_at; k++) begin
            drive(INST_MUL, a, b, (k == kill_at) && !use_rst, (k == kill_at) && use_rst);
            chk($sformatf("abort stall k=%0d", k), XLEN'(mul_stall), XLEN'(k < kill_at));
            chk($sformatf("abort done k=%0d", k), XLEN'(mul_done), '0);
        end
        if (use_rst) exp_result = '0;
        for (int k = 0; k < 4; k++) begin
            drive(INST_NOP, a, b, 1'b0, 1'b0);
            chk("post-abort stall", XLEN'(mul_stall), '0);
            chk("post-abort done", XLEN'(mul_done), '0);
            chk("post-abort result", mul_result, exp_result);
        end
    endtask

    task automatic idle_cycles(input logic [31:0] inst, input int n);
        for (int k = 0; k < n; k++) begin
            drive(inst, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
            chk("non-mul stall", XLEN'(mul_stall), '0);
            chk("non-mul done", XLEN'(mul_done), '0);
            chk("non-mul result hold", mul_result, exp_result);
        end
    endtask

    initial begin
        logic [XLEN-1:0] ra;
        logic [XLEN-1:0] rb;
        rst     = 1'b1;
        ex_inst = INST_MUL;
        op_a    = 64'd3;
        op_b    = 64'd5;
        flush   = 1'b0;

        // Reset state, with a MUL present so the stall mask on rst is exercised.
        drive(INST_MUL, 64'd3, 64'd5, 1'b0, 1'b1);
        drive(INST_MUL, 64'd3, 64'd5, 1'b0, 1'b1);
        chk("reset stall", XLEN'(mul_stall), '0);
        chk("reset done", XLEN'(mul_done), '0);
        chk("reset result", mul_result, '0);
        idle_cycles(INST_NOP, 2);

        // Directed products, including wrap cases and back-to-back issue.
        run_mul(64'd3, 64'd5);
        run_mul(64'd7, 64'd6);
        run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        run_mul(64'h8000_0000_0000_0000, 64'd2);
        run_mul(64'd7, 64'd3);
        run_mul(64'd9, 64'd0);
        run_mul(64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0001);

        // Near-miss encodings and ADD never stall.
        idle_cycles(INST_ADD, 4);
        idle_cycles(INST_MULH, 2);
        idle_cycles(INST_MULW, 2);

        // Flush while idle with a MUL in EX: no start that cycle.
        drive(INST_MUL, 64'd11, 64'd13, 1'b1, 1'b0);
        chk("idle flush stall", XLEN'(mul_stall), '0);
        run_mul(64'd11, 64'd13);

        // Flush mid-run, then reset mid-run.
        abort_mul(64'hDEAD_BEEF_0000_0001, 64'h8000_0000_0000_0003, 10, 1'b0);
        run_mul(64'd3, 64'd5);
        abort_mul(64'hCAFE_F00D_1234_5678, 64'hF000_0000_0000_0000, 20, 1'b1);

        // Random operands with mixed multiplier shapes and gaps.
        for (int n = 0; n < 30; n++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rb = {$urandom, $urandom};
                1:       rb = XLEN'($urandom_range(0, 255));
                2:       rb = '0;
                default: rb = XLEN'(1) << $urandom_range(0, XLEN - 1);
            endcase
            run_mul(ra, rb);
            if ($urandom_range(0, 1) == 1) idle_cycles(INST_ADD, int'($urandom_range(1, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
